// File: rtl/motor_ctrl_pkg.sv
// Shared constants for the motor control slice: FSM state encoding, default widths and
// clock-derived cycle counts.
package motor_ctrl_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned RETRY_W = 4;

   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ST_RAMP     = 3'd1;
   localparam logic [STATE_W-1:0] ST_RUN      = 3'd2;
   localparam logic [STATE_W-1:0] ST_TRIPPED  = 3'd3;
   localparam logic [STATE_W-1:0] ST_COOLDOWN = 3'd4;
   localparam logic [STATE_W-1:0] ST_RELEASE  = 3'd5;
   localparam logic [STATE_W-1:0] ST_LOCKOUT  = 3'd6;

   localparam int unsigned DUTY_W_DEF    = 8;
   localparam int unsigned CLK_FREQ_HZ   = 100_000_000;
   localparam int unsigned COOLDOWN_DEF  = CLK_FREQ_HZ / 2;
   localparam int unsigned RAMP_STEP_DEF = 65536;

   // Retry counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] cnt);
      return (cnt == {RETRY_W{1'b1}}) ? cnt : cnt + RETRY_W'(1);
   endfunction

endpackage

// File: rtl/duty_ramp.sv
// Soft-start duty stepper: a prescaler that advances duty by one per RAMP_STEP_CYCLES,
// saturating at target, plus an immediate clamp whenever target drops below duty.
module duty_ramp
   import motor_ctrl_pkg::*;
#(
   parameter int unsigned DUTY_W           = DUTY_W_DEF,
   parameter int unsigned RAMP_STEP_CYCLES = RAMP_STEP_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              start,
   input  logic              step_en,
   input  logic [DUTY_W-1:0] target,
   output logic [DUTY_W-1:0] duty,
   output logic              at_target_c
);

   localparam int unsigned PRESC_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_STEP_CYCLES - 1);

   logic [PRESC_W-1:0] presc;
   logic               step_c;
   logic [DUTY_W-1:0]  duty_nxt_c;

   // Next duty: clamp down first, otherwise one saturating step when the prescaler wraps.
   always_comb begin
      step_c     = step_en && (presc == PRESC_LAST);
      duty_nxt_c = duty;
      if (target < duty) begin
         duty_nxt_c = target;
      end else if (step_c && (duty < target)) begin
         duty_nxt_c = duty + DUTY_W'(1);
      end
   end

   assign at_target_c = (duty_nxt_c == target);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         duty  <= '0;
         presc <= '0;
      end else begin
         duty <= duty_nxt_c;
         if (start) begin
            presc <= '0;
         end else if (step_en) begin
            presc <= step_c ? '0 : presc + PRESC_W'(1);
         end
      end
   end

endmodule

// File: rtl/motor_fault_sequencer.sv
// Supervisory sequencer around the over-current limiter: soft-start, trip stop, cooldown,
// limiter release and retry-limited lockout. Define RETRY_BACKOFF_EN to double the cooldown per retry.
module motor_fault_sequencer
   import motor_ctrl_pkg::*;
#(
   parameter int unsigned DUTY_W           = DUTY_W_DEF,
   parameter int unsigned RAMP_STEP_CYCLES = RAMP_STEP_DEF,
   parameter int unsigned COOLDOWN_CYCLES  = COOLDOWN_DEF,
   parameter int unsigned MAX_RETRIES      = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [DUTY_W-1:0]  duty_cmd,
   input  logic               trip,
   input  logic               clear_fault,
   output logic [DUTY_W-1:0]  duty_out,
   output logic               motor_stop,
   output logic               end_reset,
   output logic [RETRY_W-1:0] retry_count,
   output logic               fault_latched,
   output logic [STATE_W-1:0] state_o
);

   localparam int unsigned BASE_TMR_W = $clog2(COOLDOWN_CYCLES + 1);
`ifdef RETRY_BACKOFF_EN
   localparam int unsigned TMR_W = BASE_TMR_W + MAX_RETRIES;
`else
   localparam int unsigned TMR_W = BASE_TMR_W;
`endif
   localparam logic [TMR_W-1:0]   COOL_LOAD   = TMR_W'(COOLDOWN_CYCLES);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt_c;
   logic [TMR_W-1:0]   timer;
   logic [TMR_W-1:0]   timer_nxt_c;
   logic [RETRY_W-1:0] retry_nxt_c;
   logic               end_reset_nxt_c;
   logic               ramp_clear_c;
   logic               ramp_start_c;
   logic               ramp_step_en_c;
   logic               at_target_c;

   assign state_o = state;

   // Next-state and next-output decode.
   always_comb begin
      state_nxt_c     = state;
      timer_nxt_c     = timer;
      retry_nxt_c     = retry_count;
      end_reset_nxt_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) state_nxt_c = ST_RAMP;
         end
         ST_RAMP: begin
            if (trip) begin
               state_nxt_c = ST_TRIPPED;
               retry_nxt_c = retry_inc(retry_count);
            end else if (!enable) begin
               state_nxt_c = ST_IDLE;
               retry_nxt_c = '0;
            end else if (at_target_c) begin
               state_nxt_c = ST_RUN;
            end
         end
         ST_RUN: begin
            if (trip) begin
               state_nxt_c = ST_TRIPPED;
               retry_nxt_c = retry_inc(retry_count);
            end else if (!enable) begin
               state_nxt_c = ST_IDLE;
               retry_nxt_c = '0;
            end else if (duty_cmd > duty_out) begin
               state_nxt_c = ST_RAMP;
            end
         end
         ST_TRIPPED: begin
            if (retry_count > RETRY_LIMIT) begin
               state_nxt_c = ST_LOCKOUT;
            end else begin
               state_nxt_c = ST_COOLDOWN;
`ifdef RETRY_BACKOFF_EN
               timer_nxt_c = COOL_LOAD << (retry_count - RETRY_W'(1));
`else
               timer_nxt_c = COOL_LOAD;
`endif
            end
         end
         ST_COOLDOWN: begin
            if (timer <= TMR_W'(1)) begin
               state_nxt_c = ST_RELEASE;
               timer_nxt_c = '0;
            end else begin
               timer_nxt_c = timer - TMR_W'(1);
            end
         end
         ST_RELEASE: begin
            state_nxt_c = enable ? ST_RAMP : ST_IDLE;
         end
         ST_LOCKOUT: begin
            if (clear_fault) begin
               state_nxt_c     = ST_IDLE;
               retry_nxt_c     = '0;
               end_reset_nxt_c = 1'b1;
            end
         end
         default: begin
            state_nxt_c = ST_IDLE;
         end
      endcase
      if (state_nxt_c == ST_RELEASE) end_reset_nxt_c = 1'b1;
   end

   // Drive is live only in RAMP/RUN; the prescaler restarts on every RAMP entry.
   always_comb begin
      ramp_clear_c   = !((state_nxt_c == ST_RAMP) || (state_nxt_c == ST_RUN));
      ramp_start_c   = (state_nxt_c == ST_RAMP) && (state != ST_RAMP);
      ramp_step_en_c = (state == ST_RAMP);
   end

   duty_ramp #(
      .DUTY_W           (DUTY_W),
      .RAMP_STEP_CYCLES (RAMP_STEP_CYCLES)
   ) u_duty_ramp (
      .clock       (clock),
      .reset       (reset),
      .clear       (ramp_clear_c),
      .start       (ramp_start_c),
      .step_en     (ramp_step_en_c),
      .target      (duty_cmd),
      .duty        (duty_out),
      .at_target_c (at_target_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         timer         <= '0;
         retry_count   <= '0;
         end_reset     <= 1'b0;
         motor_stop    <= 1'b1;
         fault_latched <= 1'b0;
      end else begin
         state         <= state_nxt_c;
         timer         <= timer_nxt_c;
         retry_count   <= retry_nxt_c;
         end_reset     <= end_reset_nxt_c;
         motor_stop    <= ramp_clear_c;
         fault_latched <= (state_nxt_c == ST_LOCKOUT);
      end
   end

endmodule

// File: tb/tb_motor_fault_sequencer.sv
// Directed bench for motor_fault_sequencer with short ramp/cooldown parameters.
// Build with RETRY_BACKOFF_EN defined to expect doubling cooldowns.
module tb_motor_fault_sequencer;

   localparam int unsigned DUTY_W = 8;
   localparam int unsigned COOL   = 20;

   logic              clock;
   logic              reset;
   logic              enable;
   logic [DUTY_W-1:0] duty_cmd;
   logic              trip;
   logic              clear_fault;
   logic [DUTY_W-1:0] duty_out;
   logic              motor_stop;
   logic              end_reset;
   logic [3:0]        retry_count;
   logic              fault_latched;
   logic [2:0]        state_o;

   int total;
   int bad;

   motor_fault_sequencer #(
      .DUTY_W           (DUTY_W),
      .RAMP_STEP_CYCLES (4),
      .COOLDOWN_CYCLES  (COOL),
      .MAX_RETRIES      (2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .duty_cmd      (duty_cmd),
      .trip          (trip),
      .clear_fault   (clear_fault),
      .duty_out      (duty_out),
      .motor_stop    (motor_stop),
      .end_reset     (end_reset),
      .retry_count   (retry_count),
      .fault_latched (fault_latched),
      .state_o       (state_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs and next inputs both settle 1 time unit after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int cool_len(input int retries);
`ifdef RETRY_BACKOFF_EN
      return COOL << (retries - 1);
`else
      return COOL;
`endif
   endfunction

   // Called right after TRIPPED is observed; counts COOLDOWN cycles and checks RELEASE.
   task automatic run_cooldown(input string tag, input int retries);
      int n;
      n = 0;
      tick();
      while (state_o == 3'd4 && n < 500) begin
         n++;
         tick();
      end
      check({tag, "_len"}, 32'(n), 32'(cool_len(retries)));
      check({tag, "_rel_st"}, 32'(state_o), 32'd5);
      check({tag, "_rel_er"}, 32'(end_reset), 32'd1);
   endtask

   initial begin
      bit er_seen;
      total       = 0;
      bad         = 0;
      reset       = 1'b1;
      enable      = 1'b0;
      duty_cmd    = '0;
      trip        = 1'b0;
      clear_fault = 1'b0;
      tick();
      tick();
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_duty", 32'(duty_out), 32'd0);
      check("rst_stop", 32'(motor_stop), 32'd1);
      check("rst_er", 32'(end_reset), 32'd0);
      check("rst_retry", 32'(retry_count), 32'd0);
      check("rst_fault", 32'(fault_latched), 32'd0);
      reset = 1'b0;
      tick();
      check("idle_hold", 32'(state_o), 32'd0);

      // Soft-start to 5: one step every 4 clocks, RUN on the edge duty hits 5.
      duty_cmd = 8'd5;
      enable   = 1'b1;
      tick();
      check("ss_state0", 32'(state_o), 32'd1);
      check("ss_duty0", 32'(duty_out), 32'd0);
      check("ss_stop0", 32'(motor_stop), 32'd0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         check($sformatf("ss_duty%0d", k), 32'(duty_out), 32'(k / 4));
         check($sformatf("ss_state%0d", k), 32'(state_o), (k == 20) ? 32'd2 : 32'd1);
         check($sformatf("ss_stop%0d", k), 32'(motor_stop), 32'd0);
      end
      tick();
      check("run_hold", 32'(duty_out), 32'd5);

      // Command decrease follows in one cycle; increase re-ramps from current duty.
      duty_cmd = 8'd2;
      tick();
      check("dec_duty", 32'(duty_out), 32'd2);
      check("dec_state", 32'(state_o), 32'd2);
      duty_cmd = 8'd3;
      tick();
      check("inc_state", 32'(state_o), 32'd1);
      check("inc_duty", 32'(duty_out), 32'd2);
      for (int k = 0; k < 3; k++) tick();
      check("inc_duty3", 32'(duty_out), 32'd2);
      tick();
      check("inc_duty4", 32'(duty_out), 32'd3);
      check("inc_run", 32'(state_o), 32'd2);

      // Single trip from RUN.
      trip = 1'b1;
      tick();
      trip = 1'b0;
      check("t1_state", 32'(state_o), 32'd3);
      check("t1_duty", 32'(duty_out), 32'd0);
      check("t1_stop", 32'(motor_stop), 32'd1);
      check("t1_retry", 32'(retry_count), 32'd1);
      run_cooldown("t1_cool", 1);
      tick();
      check("t1_ramp", 32'(state_o), 32'd1);
      check("t1_er_off", 32'(end_reset), 32'd0);
      check("t1_duty_r", 32'(duty_out), 32'd0);
      check("t1_retry_h", 32'(retry_count), 32'd1);
      for (int k = 0; k < 4; k++) tick();
      check("t1_step", 32'(duty_out), 32'd1);

      // Second trip (cooldown doubles under backoff), third trip locks out.
      trip = 1'b1;
      tick();
      trip = 1'b0;
      check("t2_retry", 32'(retry_count), 32'd2);
      run_cooldown("t2_cool", 2);
      tick();
      check("t2_ramp", 32'(state_o), 32'd1);
      trip = 1'b1;
      tick();
      trip = 1'b0;
      check("t3_retry", 32'(retry_count), 32'd3);
      tick();
      check("lk_state", 32'(state_o), 32'd6);
      check("lk_fault", 32'(fault_latched), 32'd1);
      check("lk_stop", 32'(motor_stop), 32'd1);
      for (int k = 0; k < 5; k++) tick();
      check("lk_hold", 32'(state_o), 32'd6);
      check("lk_duty", 32'(duty_out), 32'd0);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("clr_state", 32'(state_o), 32'd0);
      check("clr_er", 32'(end_reset), 32'd1);
      check("clr_retry", 32'(retry_count), 32'd0);
      check("clr_fault", 32'(fault_latched), 32'd0);
      tick();
      check("clr_ramp", 32'(state_o), 32'd1);
      check("clr_er_off", 32'(end_reset), 32'd0);

      // Trip wins over enable drop; reset mid-cooldown returns to IDLE with no release pulse.
      trip   = 1'b1;
      enable = 1'b0;
      tick();
      trip = 1'b0;
      check("pri_state", 32'(state_o), 32'd3);
      check("pri_retry", 32'(retry_count), 32'd1);
      for (int k = 0; k < 6; k++) tick();
      check("pri_cool", 32'(state_o), 32'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rc_state", 32'(state_o), 32'd0);
      check("rc_retry", 32'(retry_count), 32'd0);
      check("rc_stop", 32'(motor_stop), 32'd1);
      check("rc_duty", 32'(duty_out), 32'd0);
      er_seen = end_reset;
      for (int k = 0; k < 40; k++) begin
         tick();
         er_seen = er_seen | end_reset;
      end
      check("rc_no_er", 32'(er_seen), 32'd0);
      check("rc_idle", 32'(state_o), 32'd0);

      // Zero command reaches RUN after one cycle; enable drop returns to IDLE.
      duty_cmd = 8'd0;
      enable   = 1'b1;
      tick();
      check("z_ramp", 32'(state_o), 32'd1);
      tick();
      check("z_run", 32'(state_o), 32'd2);
      check("z_duty", 32'(duty_out), 32'd0);
      enable = 1'b0;
      tick();
      check("off_state", 32'(state_o), 32'd0);
      check("off_stop", 32'(motor_stop), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
